esn_phase_ctrl: RTL and testbench
=================================

# esn_phase_ctrl

Run-phase sequencer for the echo-state network. Sits beside the reservoir/readout pair and owns their reset and enable lines. It steps a run through reservoir washout, readout training, readout test/output, and done. Phase boundaries are counted in data epochs, detected from the reservoir's data-address wrap.

## Interface

Parameters:
- ADDR_W, 6, width of reservoir data address; one epoch = one wrap of 2^ADDR_W addresses
- CNT_W, 8, width of washout/epoch length fields and counters

Ports:
- clk  in  1  system clock
- rst_N  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request; honoured in IDLE or DONE only
- abort  in  1  return to IDLE from any state; priority over start
- washout_len  in  CNT_W  washout length in cycles, sampled on accepted start
- train_epochs  in  CNT_W  training epochs, sampled on accepted start
- test_epochs  in  CNT_W  test epochs, sampled on accepted start
- data_addr  in  ADDR_W  reservoir data address (DATA_ADDR)
- res_rst_N  out  1  reservoir reset, active-low
- rdout_rst_N  out  1  readout reset, active-low
- rdout_ce  out  1  readout output enable
- phase  out  3  0 IDLE, 1 WASH, 2 TRAIN, 3 TEST, 4 DONE
- epoch  out  CNT_W  completed epochs in current phase
- busy  out  1  high in WASH, TRAIN, TEST
- done  out  1  high in DONE

## Operation

- All outputs are registered and are pure functions of state, except epoch, which is a counter.
- Reset values: phase=0, res_rst_N=0, rdout_rst_N=0, rdout_ce=0, epoch=0, busy=0, done=0. Internal address history is cleared to 0.
- Wrap detect: register addr_q <= data_addr every cycle. wrap = (addr_q == 2^ADDR_W-1) && (data_addr == 0). Only wraps seen in TRAIN/TEST count.
- IDLE: both blocks held in reset, ce=0. On start (and no abort), latch the three length fields, load the wash counter, and go to WASH.
- WASH: res_rst_N=1, rdout_rst_N=0, ce=0. Lasts exactly max(washout_len,1) cycles. Then:
  - go to TRAIN if latched train_epochs≠0;
  - else go to TEST if test_epochs≠0;
  - else go to DONE.
- TRAIN: res_rst_N=1, rdout_rst_N=1, ce=0. Each wrap increments epoch. On the wrap that makes epoch == train_epochs, the next state is TEST (or DONE if test_epochs=0) and epoch clears to 0.
- TEST: as TRAIN but ce=1. On the wrap that reaches test_epochs, go to DONE. epoch is held at test_epochs in DONE.
- DONE: res_rst_N=1, rdout_rst_N=1 (learned weights preserved), ce=0.
  - start: restart into WASH with a fresh latch. The readout is re-reset during WASH.
  - abort: go to IDLE.
- Phase entry clears epoch, except on entry to DONE.
- abort in any state: next state is IDLE, epoch cleared.
- start in WASH/TRAIN/TEST: ignored. Length inputs changing mid-run have no effect.
- Async reset mid-run forces reset values immediately, regardless of clk.
- Counter saturation: none needed; epoch never exceeds its latched target.

## Timing

- start sampled at edge k in IDLE: phase=1, res_rst_N=1, busy=1 visible after edge k.
- WASH with washout_len=L≥1: phase=1 for exactly L cycles. rdout_rst_N rises together with phase=2.
- A wrap seen at edge m (data_addr==0 at m, addr_q==max): epoch increments after edge m. If it is the last epoch, the phase changes after the same edge m.
- rdout_ce rises and falls in the same cycle phase enters or leaves 3. There is zero-cycle skew between the phase and control outputs.
- The first TRAIN epoch may be partial; counting is strictly by wraps.
- Simultaneous start and abort: abort wins; stay in or go to IDLE.
- The readout's own reset-delay chain is downstream and is not compensated here.

## Test plan

- Reset, then start with L=4, train=2, test=1, and data_addr counting 0..63 free-running from WASH entry.
  - Required: WASH for 4 cycles.
  - Required: TRAIN ends on the 2nd wrap with ce=0 throughout.
  - Required: TEST shows ce=1 until the next wrap, then DONE with done=1, epoch=1, rdout_rst_N=1.
- Zero lengths: L=0, train=0, test=0.
  - Required: WASH lasts 1 cycle, then DONE directly; ce never asserts.
  - With train=0, test=2: WASH goes straight to TEST and 2 wraps are counted.
- Abort in TRAIN after 1 wrap.
  - Required: IDLE next cycle, res_rst_N=0, rdout_rst_N=0, epoch=0.
  - Required: start and abort asserted together in IDLE leave the block in IDLE.
- start pulses during WASH and TEST.
  - Required: ignored.
  - Required: changing train_epochs mid-run does not alter the epoch count at which TRAIN exits.
- Restart from DONE.
  - Required: WASH re-entered, rdout_rst_N=0 for L cycles, and a full sequence repeats.
  - Required: data_addr jumping 63→5 does not count as a wrap.
- Async rst_N low mid-TEST, between clock edges.
  - Required: all outputs take reset values immediately; after release the block stays in IDLE until start.

Source files
------------

// File: rtl/esn_phase_ctrl.sv
// -----------------------------------------------------------------------------
// esn_phase_ctrl
// Run-phase sequencer for the echo-state network. It owns the reset and
// enable lines of the reservoir/readout pair and steps one run through
// washout, readout training, readout test/output and done. Washout is timed
// in clock cycles. Training and test are timed in data epochs. An epoch ends
// when the reservoir data address wraps from its maximum value back to zero.
//
// Parameters
//   ADDR_W        width of the reservoir data address (epoch = 2^ADDR_W addrs)
//   CNT_W         width of the length fields and of the epoch counter
//
// Ports
//   clk           system clock
//   rst_N         asynchronous active-low reset
//   start         single-cycle run request, honoured in IDLE or DONE only
//   abort         return to IDLE from any state, wins over start
//   washout_len   washout length in cycles (latched on accepted start)
//   train_epochs  training epochs (latched on accepted start)
//   test_epochs   test epochs (latched on accepted start)
//   data_addr     reservoir data address, used for wrap detection
//   res_rst_N     reservoir reset, active-low
//   rdout_rst_N   readout reset, active-low
//   rdout_ce      readout output enable
//   phase         0 IDLE, 1 WASH, 2 TRAIN, 3 TEST, 4 DONE
//   epoch         completed epochs in the current phase
//   busy          high in WASH, TRAIN and TEST
//   done          high in DONE
// -----------------------------------------------------------------------------
module esn_phase_ctrl #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_N,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  washout_len,
  input  logic [CNT_W-1:0]  train_epochs,
  input  logic [CNT_W-1:0]  test_epochs,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              res_rst_N,
  output logic              rdout_rst_N,
  output logic              rdout_ce,
  output logic [2:0]        phase,
  output logic [CNT_W-1:0]  epoch,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_TRAIN = 3'd2,
    S_TEST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t            r_state;
  state_t            w_nxt_state;
  logic [ADDR_W-1:0] r_addr_q;
  logic [CNT_W-1:0]  r_wash_cnt;
  logic [CNT_W-1:0]  w_nxt_wash_cnt;
  logic [CNT_W-1:0]  r_train_len;
  logic [CNT_W-1:0]  w_nxt_train_len;
  logic [CNT_W-1:0]  r_test_len;
  logic [CNT_W-1:0]  w_nxt_test_len;
  logic [CNT_W-1:0]  r_epoch;
  logic [CNT_W-1:0]  w_nxt_epoch;
  logic [CNT_W-1:0]  w_epoch_inc;
  logic              w_wrap;

  logic              r_res_rst_n;
  logic              r_rdout_rst_n;
  logic              r_rdout_ce;
  logic              r_busy;
  logic              r_done;

  // A jump such as 63 -> 5 is not an epoch boundary. Only the exact
  // max -> 0 step counts.
  assign w_wrap      = (r_addr_q == ADDR_MAX) && (data_addr == '0);
  assign w_epoch_inc = r_epoch + CNT_ONE;

  // Address history runs in every state.
  // Wraps are only acted on in TRAIN/TEST.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_addr_q <= '0;
    end else begin
      r_addr_q <= data_addr;
    end
  end

  // Next-state and counter logic.
  // The length fields are taken from the inputs only on an accepted start.
  // This keeps a run immune to mid-run changes on those inputs.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_wash_cnt  = r_wash_cnt;
    w_nxt_train_len = r_train_len;
    w_nxt_test_len  = r_test_len;
    w_nxt_epoch     = r_epoch;

    if (abort) begin
      w_nxt_state = S_IDLE;
      w_nxt_epoch = '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_nxt_state     = S_WASH;
            w_nxt_train_len = train_epochs;
            w_nxt_test_len  = test_epochs;
            // A zero washout still spends one cycle in WASH.
            w_nxt_wash_cnt  = (washout_len == '0) ? CNT_ONE : washout_len;
            w_nxt_epoch     = '0;
          end
        end
        S_WASH: begin
          // The counter holds the number of WASH cycles left, this one
          // included. The <= guard means a corrupted zero count still exits.
          if (r_wash_cnt <= CNT_ONE) begin
            w_nxt_epoch = '0;
            if (r_train_len != '0) begin
              w_nxt_state = S_TRAIN;
            end else if (r_test_len != '0) begin
              w_nxt_state = S_TEST;
            end else begin
              w_nxt_state = S_DONE;
            end
          end else begin
            w_nxt_wash_cnt = r_wash_cnt - CNT_ONE;
          end
        end
        S_TRAIN: begin
          if (w_wrap) begin
            if (w_epoch_inc == r_train_len) begin
              w_nxt_epoch = '0;
              w_nxt_state = (r_test_len != '0) ? S_TEST : S_DONE;
            end else begin
              w_nxt_epoch = w_epoch_inc;
            end
          end
        end
        S_TEST: begin
          // The final count is kept in epoch after the move to DONE.
          if (w_wrap) begin
            w_nxt_epoch = w_epoch_inc;
            if (w_epoch_inc == r_test_len) begin
              w_nxt_state = S_DONE;
            end
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_epoch = '0;
        end
      endcase
    end
  end

  // State, counters and latched run parameters.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_state     <= S_IDLE;
      r_wash_cnt  <= '0;
      r_train_len <= '0;
      r_test_len  <= '0;
      r_epoch     <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_wash_cnt  <= w_nxt_wash_cnt;
      r_train_len <= w_nxt_train_len;
      r_test_len  <= w_nxt_test_len;
      r_epoch     <= w_nxt_epoch;
    end
  end

  // The control outputs are decoded from the next state and then registered.
  // As a result they change on the same edge as phase, with no skew.
  // The readout stays out of reset in DONE so that its learned weights
  // survive until the next run re-resets it during WASH.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_res_rst_n   <= 1'b0;
      r_rdout_rst_n <= 1'b0;
      r_rdout_ce    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_res_rst_n   <= (w_nxt_state != S_IDLE);
      r_rdout_rst_n <= (w_nxt_state == S_TRAIN) || (w_nxt_state == S_TEST) ||
                       (w_nxt_state == S_DONE);
      r_rdout_ce    <= (w_nxt_state == S_TEST);
      r_busy        <= (w_nxt_state == S_WASH) || (w_nxt_state == S_TRAIN) ||
                       (w_nxt_state == S_TEST);
      r_done        <= (w_nxt_state == S_DONE);
    end
  end

  assign phase       = r_state;
  assign epoch       = r_epoch;
  assign res_rst_N   = r_res_rst_n;
  assign rdout_rst_N = r_rdout_rst_n;
  assign rdout_ce    = r_rdout_ce;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_esn_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_esn_phase_ctrl
// Self-checking bench for esn_phase_ctrl. A run-level reference model tracks
// the phase, epoch count and remaining washout. It works in plain integers,
// starting from the sequencing rules. Each scenario task compares the DUT
// outputs against that model every cycle. Each task also checks its own
// scenario-specific facts against constants.
// -----------------------------------------------------------------------------
module tb_esn_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_N;
  logic       start;
  logic       abort;
  logic [7:0] washout_len;
  logic [7:0] train_epochs;
  logic [7:0] test_epochs;
  logic [5:0] data_addr;
  logic       res_rst_N;
  logic       rdout_rst_N;
  logic       rdout_ce;
  logic [2:0] phase;
  logic [7:0] epoch;
  logic       busy;
  logic       done;

  int passCnt  = 0;
  int totalCnt = 0;
  bit addrRun  = 1'b0;

  // Reference model state.
  int mPhase = 0;
  int mEpoch = 0;
  int mWashLeft = 0;
  int mTrain = 0;
  int mTest = 0;
  int mPrevAddr = 0;

  esn_phase_ctrl #(.ADDR_W(6), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_N        (rst_N),
    .start        (start),
    .abort        (abort),
    .washout_len  (washout_len),
    .train_epochs (train_epochs),
    .test_epochs  (test_epochs),
    .data_addr    (data_addr),
    .res_rst_N    (res_rst_N),
    .rdout_rst_N  (rdout_rst_N),
    .rdout_ce     (rdout_ce),
    .phase        (phase),
    .epoch        (epoch),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  wire [15:0] dutVec = {phase, epoch, res_rst_N, rdout_rst_N, rdout_ce, busy, done};

  // Expected output word, derived from the model phase alone (plus epoch).
  function automatic logic [15:0] expVec();
    logic [2:0] p;
    logic [7:0] e;
    p = 3'(mPhase);
    e = 8'(mEpoch);
    return {p, e, mPhase != 0, mPhase >= 2, mPhase == 3,
            mPhase >= 1 && mPhase <= 3, mPhase == 4};
  endfunction

  function automatic void modelReset();
    mPhase = 0; mEpoch = 0; mWashLeft = 0; mTrain = 0; mTest = 0; mPrevAddr = 0;
  endfunction

  // One clock edge of the run-level rules.
  function automatic void modelClock(bit st, bit ab, int addr);
    bit wrap;
    wrap = (mPrevAddr == 63) && (addr == 0);
    mPrevAddr = addr;
    if (ab) begin
      mPhase = 0;
      mEpoch = 0;
      return;
    end
    case (mPhase)
      0, 4: if (st) begin
        mTrain = int'(train_epochs);
        mTest = int'(test_epochs);
        mWashLeft = (washout_len == 0) ? 1 : int'(washout_len);
        mEpoch = 0;
        mPhase = 1;
      end
      1: begin
        mWashLeft = mWashLeft - 1;
        if (mWashLeft == 0) begin
          mEpoch = 0;
          mPhase = (mTrain != 0) ? 2 : (mTest != 0) ? 3 : 4;
        end
      end
      2: if (wrap) begin
        mEpoch = mEpoch + 1;
        if (mEpoch == mTrain) begin
          mEpoch = 0;
          mPhase = (mTest != 0) ? 3 : 4;
        end
      end
      3: if (wrap) begin
        mEpoch = mEpoch + 1;
        if (mEpoch == mTest) mPhase = 4;
      end
      default: ;
    endcase
  endfunction

  // Drive one cycle of inputs. Advance the model on the edge. Return 1 ns
  // later with the pulses cleared and the free-running address advanced.
  task automatic tick(input bit st, input bit ab);
    start = st;
    abort = ab;
    @(posedge clk);
    modelClock(st, ab, int'(data_addr));
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (addrRun) data_addr = data_addr + 6'd1;
  endtask

  task automatic applyStimulus(input int l, input int tr, input int te);
    washout_len = 8'(l);
    train_epochs = 8'(tr);
    test_epochs = 8'(te);
  endtask

  task automatic test_reset();
    totalCnt++;
    if (dutVec !== 16'h0000) $display("[TB] FAIL reset_values: got %h want %h", dutVec, 16'h0000);
    else passCnt++;
    rst_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      totalCnt++;
      if (dutVec !== expVec()) $display("[TB] FAIL idle_hold: got %h want %h", dutVec, expVec());
      else passCnt++;
    end
  endtask

  task automatic test_nominal();
    int washCyc = 0;
    int trainCe = 0;
    int c;
    applyStimulus(4, 2, 1);
    data_addr = 6'd63;
    addrRun = 1'b1;
    tick(1'b1, 1'b0);
    for (c = 0; c < 1000 && mPhase != 4; c++) begin
      if (phase == 3'd1) washCyc++;
      if (phase == 3'd2 && rdout_ce) trainCe++;
      tick(1'b0, 1'b0);
      totalCnt++;
      if (dutVec !== expVec()) $display("[TB] FAIL nominal_cycle: got %h want %h", dutVec, expVec());
      else passCnt++;
    end
    totalCnt++;
    if (c >= 1000) $display("[TB] FAIL nominal_timeout: got %0d cycles want <1000", c);
    else passCnt++;
    totalCnt++;
    if (washCyc != 4) $display("[TB] FAIL nominal_wash_len: got %0d want 4", washCyc);
    else passCnt++;
    totalCnt++;
    if (trainCe != 0) $display("[TB] FAIL nominal_train_ce: got %0d want 0", trainCe);
    else passCnt++;
    totalCnt++;
    if ({phase, done, epoch, rdout_rst_N, rdout_ce} !== {3'd4, 1'b1, 8'd1, 1'b1, 1'b0})
      $display("[TB] FAIL nominal_done: got ph=%0d done=%b ep=%0d rr=%b ce=%b want ph=4 done=1 ep=1 rr=1 ce=0",
               phase, done, epoch, rdout_rst_N, rdout_ce);
    else passCnt++;
  endtask

  task automatic test_zero_lengths();
    int ceSeen = 0;
    int trainSeen = 0;
    int c;
    applyStimulus(0, 0, 0);
    tick(1'b1, 1'b0);
    totalCnt++;
    if (phase !== 3'd1 || dutVec !== expVec()) $display("[TB] FAIL zero_wash: got ph=%0d want 1", phase);
    else passCnt++;
    tick(1'b0, 1'b0);
    totalCnt++;
    if (phase !== 3'd4 || rdout_ce !== 1'b0 || dutVec !== expVec())
      $display("[TB] FAIL zero_done: got ph=%0d ce=%b want ph=4 ce=0", phase, rdout_ce);
    else passCnt++;

    applyStimulus(0, 0, 2);
    tick(1'b1, 1'b0);
    for (c = 0; c < 1000 && mPhase != 4; c++) begin
      tick(1'b0, 1'b0);
      if (phase == 3'd2) trainSeen++;
      if (rdout_ce) ceSeen++;
      totalCnt++;
      if (dutVec !== expVec()) $display("[TB] FAIL test_only_cycle: got %h want %h", dutVec, expVec());
      else passCnt++;
    end
    totalCnt++;
    if (c >= 1000 || trainSeen != 0 || epoch !== 8'd2 || ceSeen == 0)
      $display("[TB] FAIL test_only_end: got cyc=%0d train=%0d ep=%0d ce=%0d want train=0 ep=2 ce>0",
               c, trainSeen, epoch, ceSeen);
    else passCnt++;
  endtask

  task automatic test_abort();
    int c;
    applyStimulus(2, 3, 1);
    tick(1'b1, 1'b0);
    for (c = 0; c < 1000 && !(mPhase == 2 && mEpoch == 1); c++) begin
      tick(1'b0, 1'b0);
      totalCnt++;
      if (dutVec !== expVec()) $display("[TB] FAIL abort_run: got %h want %h", dutVec, expVec());
      else passCnt++;
    end
    tick(1'b0, 1'b1);
    totalCnt++;
    if ({phase, res_rst_N, rdout_rst_N, epoch} !== {3'd0, 1'b0, 1'b0, 8'd0} || c >= 1000)
      $display("[TB] FAIL abort_idle: got ph=%0d rr=%b ro=%b ep=%0d want 0 0 0 0",
               phase, res_rst_N, rdout_rst_N, epoch);
    else passCnt++;
    tick(1'b1, 1'b1);
    totalCnt++;
    if (phase !== 3'd0 || busy !== 1'b0) $display("[TB] FAIL start_abort_idle: got ph=%0d want 0", phase);
    else passCnt++;
  endtask

  task automatic test_ignore_start();
    int maxTrainEp = 0;
    int c;
    applyStimulus(5, 2, 2);
    tick(1'b1, 1'b0);
    for (c = 0; c < 1000 && mPhase != 4; c++) begin
      // Pulse start in WASH and periodically in TEST. Rewrite train_epochs
      // once TRAIN is running.
      tick((mPhase == 1 && c == 1) || (mPhase == 3 && c % 17 == 0), 1'b0);
      if (mPhase == 2) train_epochs = 8'd1;
      if (phase == 3'd2 && int'(epoch) > maxTrainEp) maxTrainEp = int'(epoch);
      totalCnt++;
      if (dutVec !== expVec()) $display("[TB] FAIL ignore_start_cycle: got %h want %h", dutVec, expVec());
      else passCnt++;
    end
    totalCnt++;
    if (maxTrainEp != 1 || c >= 1000) $display("[TB] FAIL train_latch: got max epoch %0d want 1", maxTrainEp);
    else passCnt++;
  endtask

  task automatic test_restart();
    int rdRstWash = 0;
    int epBefore;
    int c;
    applyStimulus(3, 2, 1);
    tick(1'b1, 1'b0);
    if (phase == 3'd1 && !rdout_rst_N) rdRstWash++;
    for (c = 0; c < 1000 && !(mPhase == 2 && mEpoch == 1); c++) begin
      tick(1'b0, 1'b0);
      if (phase == 3'd1 && !rdout_rst_N) rdRstWash++;
      totalCnt++;
      if (dutVec !== expVec()) $display("[TB] FAIL restart_cycle: got %h want %h", dutVec, expVec());
      else passCnt++;
    end
    totalCnt++;
    if (rdRstWash != 3) $display("[TB] FAIL restart_rdout_rst: got %0d want 3", rdRstWash);
    else passCnt++;
    epBefore = mEpoch;
    addrRun = 1'b0;
    data_addr = 6'd63;
    tick(1'b0, 1'b0);
    data_addr = 6'd5;
    tick(1'b0, 1'b0);
    totalCnt++;
    if (epoch !== 8'(epBefore) || phase !== 3'd2)
      $display("[TB] FAIL jump_no_wrap: got ep=%0d ph=%0d want ep=%0d ph=2", epoch, phase, epBefore);
    else passCnt++;
    addrRun = 1'b1;
    for (c = 0; c < 1000 && mPhase != 4; c++) begin
      tick(1'b0, 1'b0);
      totalCnt++;
      if (dutVec !== expVec()) $display("[TB] FAIL restart_tail: got %h want %h", dutVec, expVec());
      else passCnt++;
    end
    totalCnt++;
    if (done !== 1'b1 || c >= 1000) $display("[TB] FAIL restart_done: got done=%b want 1", done);
    else passCnt++;
  endtask

  task automatic test_async_reset();
    int c;
    applyStimulus(1, 1, 2);
    tick(1'b1, 1'b0);
    for (c = 0; c < 1000 && mPhase != 3; c++) tick(1'b0, 1'b0);
    #3 rst_N = 1'b0;
    #1;
    totalCnt++;
    if (dutVec !== 16'h0000 || c >= 1000) $display("[TB] FAIL async_reset: got %h want %h", dutVec, 16'h0000);
    else passCnt++;
    modelReset();
    #3 rst_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      totalCnt++;
      if (phase !== 3'd0 || dutVec !== expVec()) $display("[TB] FAIL post_reset_idle: got %h want %h", dutVec, expVec());
      else passCnt++;
    end
  endtask

  task automatic test_random();
    int c;
    for (int run = 0; run < 6; run++) begin
      applyStimulus($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2));
      data_addr = 6'($urandom_range(0, 63));
      tick(1'b1, 1'b0);
      for (c = 0; c < 1000 && mPhase >= 1 && mPhase <= 3; c++) begin
        tick($urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        if ($urandom_range(0, 7) == 0) applyStimulus($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2));
        totalCnt++;
        if (dutVec !== expVec()) $display("[TB] FAIL random_cycle: got %h want %h", dutVec, expVec());
        else passCnt++;
      end
      totalCnt++;
      if (c >= 1000) $display("[TB] FAIL random_timeout: got %0d cycles want <1000", c);
      else passCnt++;
    end
  endtask

  initial begin
    rst_N = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    data_addr = 6'd0;
    applyStimulus(0, 0, 0);
    modelReset();
    #2;
    test_reset();
    test_nominal();
    test_zero_lengths();
    test_abort();
    test_ignore_start();
    test_restart();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
